uart_rx_fifo: RTL and testbench

Parametrised successor to the camera UART-to-FIFO path. It contains an oversampling UART receiver with configurable data bits and parity, feeding a single-clock FIFO of configurable width and depth. The FIFO has a first-word-fall-through read port, level reporting, almost-full and sticky error flags. It sits between the external `rx` pin and the capture/pixel logic and replaces the old `rx_busy`-derived write clock with a proper one-cycle write strobe in the `clk` domain.

---
 rtl/uart_fifo_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 74 +++++++
 rtl/uart_rx_fifo.sv | 159 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_fifo_pkg.sv
// Shared constants, receiver state encoding and sizing helper for the UART-to-FIFO path.
package uart_fifo_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through registered read port and
// level-derived flags registered alongside the level counter.
module sync_fifo
  import uart_fifo_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned DEPTH        = 64,
  parameter int unsigned AFULL_THRESH = 48
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          empty,
  output logic                          full,
  output logic                          almost_full,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = level_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [LW-1:0]    level_nx;
  logic             do_wr;
  logic             do_rd;

  always_comb begin
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || rd_en);
    rd_next  = rd_ptr + 1'b1;
    level_nx = level;
    case ({do_wr, do_rd})
      2'b10:   level_nx = level + 1'b1;
      2'b01:   level_nx = level - 1'b1;
      default: level_nx = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      rd_data     <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_next;
      // rd_data is a register holding the head; bypass wr_data when the
      // incoming word becomes the head in the same cycle.
      if (do_rd)
        rd_data <= (do_wr && level == LW'(1)) ? wr_data : mem[rd_next];
      else if (do_wr && empty)
        rd_data <= wr_data;
      level       <= level_nx;
      empty       <= (level_nx == '0);
      full        <= (level_nx == LW'(DEPTH));
      almost_full <= (level_nx >= LW'(AFULL_THRESH));
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a sync_fifo through a one-cycle write
// strobe, with sticky overflow/frame/parity error flags.
module uart_rx_fifo
  import uart_fifo_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned AFULL_THRESH = 48
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               rx,
  input  logic                               rd_en,
  output logic [DATA_BITS-1:0]               rd_data,
  output logic                               empty,
  output logic                               full,
  output logic                               almost_full,
  output logic [level_width(FIFO_DEPTH)-1:0] level,
  output logic                               rx_busy,
  output logic                               overflow,
  output logic                               frame_err,
  output logic                               parity_err,
  input  logic                               clr_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  rx_state_e            state, state_nx;
  logic                 rx_s1, rx_s2, rx_prev;
  logic                 fall;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [2:0]           bit_idx, bit_nx;
  logic [DATA_BITS-1:0] data_sr, sr_nx;
  logic                 par_bad, par_bad_nx;
  logic                 wr_strobe, wr_nx;
  logic                 set_fe, set_pe, set_ovf;

  assign fall = rx_prev && !rx_s2;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + 1'b1;
    bit_nx     = bit_idx;
    sr_nx      = data_sr;
    par_bad_nx = par_bad;
    wr_nx      = 1'b0;
    set_fe     = 1'b0;
    set_pe     = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (fall) begin
          state_nx   = ST_START;
          bit_nx     = '0;
          par_bad_nx = 1'b0;
        end
      end
      ST_START: begin
        if (cnt == HALF_M1) begin
          cnt_nx   = '0;
          state_nx = rx_s2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt == BIT_M1) begin
          cnt_nx = '0;
          sr_nx  = {rx_s2, data_sr[DATA_BITS-1:1]};
          bit_nx = bit_idx + 1'b1;
          if (bit_idx == LAST_BIT)
            state_nx = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (cnt == BIT_M1) begin
          cnt_nx     = '0;
          par_bad_nx = (PARITY == PAR_ODD) ? !(^data_sr ^ rx_s2) : (^data_sr ^ rx_s2);
          state_nx   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt == BIT_M1) begin
          cnt_nx = '0;
          if (!rx_s2) begin
            set_fe   = 1'b1;
            state_nx = ST_WAIT_IDLE;
          end else if (par_bad) begin
            set_pe   = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            wr_nx    = 1'b1;
            state_nx = ST_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        cnt_nx = '0;
        if (rx_s2) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign set_ovf = wr_strobe && full && !rd_en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= ST_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      data_sr    <= '0;
      par_bad    <= 1'b0;
      wr_strobe  <= 1'b0;
      rx_busy    <= 1'b0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_s1      <= rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      state      <= state_nx;
      cnt        <= cnt_nx;
      bit_idx    <= bit_nx;
      data_sr    <= sr_nx;
      par_bad    <= par_bad_nx;
      wr_strobe  <= wr_nx;
      rx_busy    <= (state_nx != ST_IDLE);
      overflow   <= set_ovf || (overflow   && !clr_err);
      frame_err  <= set_fe  || (frame_err  && !clr_err);
      parity_err <= set_pe  || (parity_err && !clr_err);
    end
  end

  sync_fifo #(
    .WIDTH        (DATA_BITS),
    .DEPTH        (FIFO_DEPTH),
    .AFULL_THRESH (AFULL_THRESH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_strobe),
    .wr_data     (data_sr),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .level       (level)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: an even-parity, depth-4 instance and an 8N1 instance driven
// with hand-built UART frames; expected values are hand-computed.
module tb_uart_rx_fifo;

  localparam int unsigned CPB = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_e, rd_en_e, clr_err_e;
  logic [7:0] rd_data_e;
  logic       empty_e, full_e, afull_e, busy_e, ovf_e, fe_e, pe_e;
  logic [2:0] level_e;
  logic       rx_n, rd_en_n, clr_err_n;
  logic [7:0] rd_data_n;
  logic       empty_n, full_n, afull_n, busy_n, ovf_n, fe_n, pe_n;
  logic [3:0] level_n;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB), .DATA_BITS (8), .PARITY (2),
    .FIFO_DEPTH (4), .AFULL_THRESH (3)
  ) dut_e (
    .clk (clk), .reset (reset), .rx (rx_e), .rd_en (rd_en_e),
    .rd_data (rd_data_e), .empty (empty_e), .full (full_e),
    .almost_full (afull_e), .level (level_e), .rx_busy (busy_e),
    .overflow (ovf_e), .frame_err (fe_e), .parity_err (pe_e),
    .clr_err (clr_err_e)
  );

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB), .DATA_BITS (8), .PARITY (0),
    .FIFO_DEPTH (8), .AFULL_THRESH (6)
  ) dut_n (
    .clk (clk), .reset (reset), .rx (rx_n), .rd_en (rd_en_n),
    .rd_data (rd_data_n), .empty (empty_n), .full (full_n),
    .almost_full (afull_n), .level (level_n), .rx_busy (busy_n),
    .overflow (ovf_n), .frame_err (fe_n), .parity_err (pe_n),
    .clr_err (clr_err_n)
  );

  typedef struct {
    logic       clr;
    logic [7:0] data;
    logic       par_ok;
    logic       stop_b;
    logic [2:0] lvl;
    logic       pe, fe, ov, full, af, empty;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx_n = v; else rx_e = v;
    repeat (CPB) @(negedge clk);
  endtask

  // sel=0: even-parity instance, sel=1: 8N1 instance; leaves the line at stop_b.
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_ok, input logic stop_b);
    logic p;
    p = ^d;
    if (!par_ok) p = ~p;
    drive(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive(sel, d[i]);
    if (!sel) drive(sel, p);
    drive(sel, stop_b);
  endtask

  task automatic pulse_clr();
    clr_err_e = 1'b1;
    @(negedge clk);
    clr_err_e = 1'b0;
  endtask

  task automatic drain(input logic [7:0] first, input int n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("drain_%0h_data", first + 8'(k)), rd_data_e, first + 8'(k));
      rd_en_e = 1'b1;
      @(negedge clk);
    end
    rd_en_e = 1'b0;
    chk("drain_empty", empty_e, 1'b1);
    chk("drain_level", level_e, 3'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 8'hA3, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 8'h01, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 8'h02, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h03, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h04, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h05, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'h5A, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    reset = 1'b0; rx_e = 1'b1; rx_n = 1'b1;
    rd_en_e = 1'b0; rd_en_n = 1'b0; clr_err_e = 1'b0; clr_err_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_level", level_e, 3'd0);
    chk("rst_empty", empty_e, 1'b1);
    chk("rst_full_afull", {full_e, afull_e}, 2'b00);
    chk("rst_rd_data", rd_data_e, 8'h00);
    chk("rst_busy", busy_e, 1'b0);
    chk("rst_errs", {ovf_e, fe_e, pe_e}, 3'b000);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // Table: parity error, fill to full, overflow, frame error.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].clr) pulse_clr();
      send_frame(1'b0, vecs[i].data, vecs[i].par_ok, vecs[i].stop_b);
      rx_e = 1'b1;
      repeat (6) @(negedge clk);
      chk($sformatf("v%0d_level", i), level_e, vecs[i].lvl);
      chk($sformatf("v%0d_pe", i), pe_e, vecs[i].pe);
      chk($sformatf("v%0d_fe", i), fe_e, vecs[i].fe);
      chk($sformatf("v%0d_ovf", i), ovf_e, vecs[i].ov);
      chk($sformatf("v%0d_full", i), full_e, vecs[i].full);
      chk($sformatf("v%0d_afull", i), afull_e, vecs[i].af);
      chk($sformatf("v%0d_empty", i), empty_e, vecs[i].empty);
      chk($sformatf("v%0d_busy", i), busy_e, 1'b0);
    end

    drain(8'h01, 4);
    pulse_clr();
    chk("clr_errs", {ovf_e, fe_e, pe_e}, 3'b000);

    // clr_err coincident with a new parity error: setting wins.
    fork
      send_frame(1'b0, 8'hA3, 1'b0, 1'b1);
      begin
        repeat (86) @(posedge clk);
        @(negedge clk); clr_err_e = 1'b1;
        @(negedge clk); clr_err_e = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    chk("set_wins_pe", pe_e, 1'b1);
    chk("set_wins_level", level_e, 3'd0);
    pulse_clr();

    // Full FIFO: pop in the same cycle as the write strobe.
    for (int i = 0; i < 4; i++) begin
      send_frame(1'b0, 8'h10 + 8'(i), 1'b1, 1'b1);
      repeat (2) @(negedge clk);
    end
    chk("pre_simul_full", {full_e, level_e}, {1'b1, 3'd4});
    fork
      send_frame(1'b0, 8'h14, 1'b1, 1'b1);
      begin
        repeat (87) @(posedge clk);
        @(negedge clk);
        chk("simul_head", rd_data_e, 8'h10);
        rd_en_e = 1'b1;
        @(negedge clk);
        rd_en_e = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    chk("simul_level", level_e, 3'd4);
    chk("simul_full", full_e, 1'b1);
    chk("simul_ovf", ovf_e, 1'b0);
    drain(8'h11, 4);

    // False start: line low for 3 cycles only.
    rx_e = 1'b0;
    repeat (3) @(negedge clk);
    rx_e = 1'b1;
    @(negedge clk);
    chk("fs_busy_high", busy_e, 1'b1);
    repeat (20) @(negedge clk);
    chk("fs_busy_low", busy_e, 1'b0);
    chk("fs_level", level_e, 3'd0);
    chk("fs_errs", {ovf_e, fe_e, pe_e}, 3'b000);

    // Break: stop bit low and line held low; receiver waits for idle.
    send_frame(1'b0, 8'h3C, 1'b1, 1'b0);
    repeat (24) @(negedge clk);
    chk("brk_fe", fe_e, 1'b1);
    chk("brk_busy", busy_e, 1'b1);
    chk("brk_level", level_e, 3'd0);
    rx_e = 1'b1;
    repeat (5) @(negedge clk);
    chk("brk_idle", busy_e, 1'b0);
    chk("brk_empty", empty_e, 1'b1);

    // Reset mid-frame with two words queued.
    send_frame(1'b0, 8'h21, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    send_frame(1'b0, 8'h22, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    chk("prerst_level", level_e, 3'd2);
    rx_e = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_e = 1'b1;
    repeat (12) @(negedge clk);
    chk("prerst_busy", busy_e, 1'b1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mrst_level", level_e, 3'd0);
    chk("mrst_flags", {empty_e, full_e, afull_e}, 3'b100);
    chk("mrst_rd_data", rd_data_e, 8'h00);
    chk("mrst_busy", busy_e, 1'b0);
    chk("mrst_errs", {ovf_e, fe_e, pe_e}, 3'b000);
    repeat (4) @(negedge clk);
    send_frame(1'b0, 8'hC3, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    chk("post_rst_level", level_e, 3'd1);
    chk("post_rst_data", rd_data_e, 8'hC3);
    chk("post_rst_errs", {ovf_e, fe_e, pe_e}, 3'b000);

    // 8N1 instance: exact strobe latency via empty, then pop.
    fork
      send_frame(1'b1, 8'h55, 1'b1, 1'b1);
      begin
        repeat (79) @(posedge clk);
        @(negedge clk);
        chk("n_empty_at_strobe", empty_n, 1'b1);
        @(negedge clk);
        chk("n_empty_after", empty_n, 1'b0);
        chk("n_level", level_n, 4'd1);
        chk("n_data", rd_data_n, 8'h55);
      end
    join
    rd_en_n = 1'b1;
    @(negedge clk);
    rd_en_n = 1'b0;
    chk("n_pop_empty", empty_n, 1'b1);
    chk("n_pop_level", level_n, 4'd0);
    chk("n_errs", {ovf_n, fe_n, pe_n, busy_n}, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
